outstanding_credit_tracker: RTL and testbench
=============================================

# outstanding_credit_tracker

Parametrised per-channel outstanding-request tracker for the front end. It sits between the address mapper and the per-type request queues. It counts requests issued but not yet completed on each of NUM_CH channels (channel 0 = read, channel 1 = write by default) and raises per-channel stop and almost-full back-pressure. It also provides a drain handshake that quiesces all channels before a mode change or refresh, and it flags protocol errors with sticky bits.

## Interface
- NUM_CH, 2, number of independent request channels (≥1)
- DEPTH, 16, entries per channel queue; a channel stops when its count equals DEPTH
- AF_MARGIN, 2, almost_full asserts when count ≥ DEPTH−AF_MARGIN (0 ≤ AF_MARGIN < DEPTH)
- CNT_W, $clog2(DEPTH+1), derived count width; not overridden
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), derived channel-index width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  mapper issues one request this cycle
- issue_ch  in  CH_W  channel of the issued request (read/write enum value)
- done  in  NUM_CH  one completion per set bit, same cycle
- drain_req  in  1  level request to quiesce all channels
- err_clr  in  1  clears all sticky error bits
- stop  out  NUM_CH  channel full or drain active; upstream must not issue on it
- almost_full  out  NUM_CH  early back-pressure hint
- count  out  NUM_CH*CNT_W  packed per-channel outstanding counts, channel 0 in LSBs
- drain_done  out  1  all channels empty and drain holding
- overflow_err  out  NUM_CH  sticky: issue accepted while stop was high
- underflow_err  out  NUM_CH  sticky: done while count was 0

## Operation
- Per channel, next count = count + inc − dec, where inc = issue_valid & (issue_ch==c) and dec = done[c].
- inc and dec in the same cycle: count unchanged, no error, including at count 0 and at DEPTH.
- inc with count==DEPTH and no dec: count holds at DEPTH and overflow_err[c] sets.
- inc while stop[c] is high because of drain but count<DEPTH: count increments and overflow_err[c] sets.
- dec with count==0 and no inc: count holds at 0 and underflow_err[c] sets.
- issue_ch ≥ NUM_CH: the issue is ignored and overflow_err[NUM_CH−1] sets.
- stop[c] = (count[c]==DEPTH) | (state≠RUN). almost_full[c] = count[c] ≥ DEPTH−AF_MARGIN.
- Drain FSM states: RUN, DRAIN, HALT.
  - RUN→DRAIN when drain_req=1.
  - DRAIN→HALT when all registered counts are 0.
  - DRAIN→RUN if drain_req drops before the channels are empty.
  - HALT→RUN when drain_req=0.
- drain_done = (state==HALT).
- Completions are still accepted in DRAIN and HALT.
- Error bits set regardless of state. err_clr clears them; a set and a clear in the same cycle leave the bit set.

## Timing
- Reset values: all counts 0, state RUN, stop 0, almost_full 0 (0 if AF_MARGIN<DEPTH), drain_done 0, all error bits 0, statistics 0.
- Reset is asynchronous. Asserting it mid-operation clears everything immediately, including a drain in progress.
- Counts, state and error bits are registered. stop, almost_full and drain_done are combinational from registered state only; there is no input-to-output path.
- An issue in cycle t that makes count=DEPTH raises stop in cycle t+1. Upstream samples stop combinationally in the same cycle it decides to issue.
- drain_req rising in cycle t puts all stop bits high from t+1.
- If the counts are already zero, drain_done is high from t+2 (one cycle in DRAIN).

## Configuration
- Macro: CREDIT_TRACKER_STATS_EN.
- When defined, the block adds outputs peak_count (NUM_CH*CNT_W) and stall_cycles (NUM_CH*16).
  - peak_count is the registered maximum count seen since reset.
  - stall_cycles increments each cycle stop[c]=1, saturates at 16'hFFFF, and is cleared by err_clr.
- When undefined, these ports and registers do not exist. Functional behaviour is otherwise identical.

## Structure
- Shared types_def package holds:
  - the request-type enum (read=0, write=1)
  - read_entries and write_entries, used as defaults for DEPTH
  - the drain-state enum (RUN, DRAIN, HALT)
- Sub-module credit_counter: one instance per channel (generate loop). It contains the count, both error bits and the optional statistics.
- The top level holds the channel decode, the FSM and output packing.

## Test plan
All scenarios use NUM_CH=2, DEPTH=4, AF_MARGIN=1.
- Four read issues, no done → count[0]=4, almost_full[0]=1 after the 3rd issue, stop[0]=1 the cycle after the 4th; stop[1] stays 0.
- At count[0]=4, issue read and done[0] in the same cycle → count holds 4, no overflow_err. Then issue alone → overflow_err[0]=1 and count stays 4.
- done[1] at count[1]=0 → underflow_err[1]=1, count 0. err_clr → underflow_err[1]=0 the next cycle.
- Counts {2,1}, drain_req=1 → stop=2'b11 next cycle. Three done pulses → drain_done=1 one cycle after the last. drain_req=0 → RUN, stop=2'b00.
- Assert rst low mid-drain with count[0]=3 → immediately all counts 0, stop 0, drain_done 0, errors 0.
- With CREDIT_TRACKER_STATS_EN defined: fill channel 0 to 4, hold for 5 cycles → peak_count[0]=4, stall_cycles[0]=5.

Source files
------------

// File: rtl/outstanding_credit_tracker_pkg.sv
// Shared request-type, depth and drain-state definitions for the outstanding credit tracker.
package types_def;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_e;

  localparam int read_entries  = 16;
  localparam int write_entries = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/outstanding_credit_tracker_credit_counter.sv
// One channel of the tracker: outstanding count, sticky error bits, optional statistics.
// Statistics registers exist only when CREDIT_TRACKER_STATS_EN is defined.
module credit_counter
  import types_def::*;
#(
  parameter int DEPTH = read_entries,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             stop,
  input  logic             ext_ovf,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err,
`ifdef CREDIT_TRACKER_STATS_EN
  output logic [CNT_W-1:0] peak_count,
  output logic [15:0]      stall_cycles,
`endif
  output logic             underflow_err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic full, empty, ovf_set, unf_set;

  assign full    = (count == FULL);
  assign empty   = (count == '0);
  // A matched issue/completion pair nets to zero and is never an error.
  assign ovf_set = (inc && !dec && stop) || ext_ovf;
  assign unf_set = dec && !inc && empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (inc && !dec && !full)
        count <= count + CNT_W'(1);
      else if (dec && !inc && !empty)
        count <= count - CNT_W'(1);
      overflow_err  <= ovf_set || (overflow_err && !err_clr);
      underflow_err <= unf_set || (underflow_err && !err_clr);
    end
  end

`ifdef CREDIT_TRACKER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_count   <= '0;
      stall_cycles <= '0;
    end else begin
      if (count > peak_count)
        peak_count <= count;
      if (err_clr)
        stall_cycles <= '0;
      else if (stop && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/outstanding_credit_tracker.sv
// Per-channel outstanding-request tracker with back-pressure and a drain handshake.
// Optional statistics outputs are enabled by CREDIT_TRACKER_STATS_EN.
//   state | meaning
//   RUN   | normal operation, stop only on full channels
//   DRAIN | all channels stopped, waiting for counts to reach zero
//   HALT  | all channels empty, drain_done held until drain_req drops
module outstanding_credit_tracker
  import types_def::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int DEPTH     = (read_entries > write_entries) ? read_entries : write_entries,
  parameter  int AF_MARGIN = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [CH_W-1:0]         issue_ch,
  input  logic [NUM_CH-1:0]       done,
  input  logic                    drain_req,
  input  logic                    err_clr,
  output logic [NUM_CH-1:0]       stop,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    drain_done,
`ifdef CREDIT_TRACKER_STATS_EN
  output logic [NUM_CH*CNT_W-1:0] peak_count,
  output logic [NUM_CH*16-1:0]    stall_cycles,
`endif
  output logic [NUM_CH-1:0]       overflow_err,
  output logic [NUM_CH-1:0]       underflow_err
);

  drain_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic             all_empty;
  logic             bad_ch;

  // An out-of-range channel is reported on the highest channel's overflow bit.
  assign bad_ch = issue_valid && (int'(issue_ch) >= NUM_CH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic inc;
    assign inc = issue_valid && (int'(issue_ch) == c);

    credit_counter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .inc          (inc),
      .dec          (done[c]),
      .stop         (stop[c]),
      .ext_ovf      ((c == NUM_CH - 1) ? bad_ch : 1'b0),
      .err_clr      (err_clr),
      .count        (cnt[c]),
      .overflow_err (overflow_err[c]),
`ifdef CREDIT_TRACKER_STATS_EN
      .peak_count   (peak_count[c*CNT_W +: CNT_W]),
      .stall_cycles (stall_cycles[c*16 +: 16]),
`endif
      .underflow_err(underflow_err[c])
    );

    assign count[c*CNT_W +: CNT_W] = cnt[c];
    assign stop[c]        = (cnt[c] == CNT_W'(DEPTH)) || (state_q != RUN);
    assign almost_full[c] = (int'(cnt[c]) >= DEPTH - AF_MARGIN);
  end

  always_comb begin
    all_empty = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      if (cnt[c] != '0) all_empty = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (all_empty) state_d = HALT;
               else if (!drain_req) state_d = RUN;
      HALT:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign drain_done = (state_q == HALT);

endmodule

// File: tb/tb_outstanding_credit_tracker.sv
// Self-checking bench for outstanding_credit_tracker (NUM_CH=2, DEPTH=4, AF_MARGIN=1).
// Define CREDIT_TRACKER_STATS_EN to also exercise the statistics outputs.
module tb_outstanding_credit_tracker;
  localparam int NCH = 2;
  localparam int DEP = 4;
  localparam int AFM = 1;
  localparam int CW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            issue_valid = 1'b0;
  logic            issue_ch = 1'b0;
  logic [NCH-1:0]  done = '0;
  logic            drain_req = 1'b0;
  logic            err_clr = 1'b0;
  logic [NCH-1:0]  stop, almost_full, overflow_err, underflow_err;
  logic [NCH*CW-1:0] count;
  logic            drain_done;
`ifdef CREDIT_TRACKER_STATS_EN
  logic [NCH*CW-1:0] peak_count;
  logic [NCH*16-1:0] stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: plain integers following the channel and drain rules.
  int m_cnt[NCH];
  bit m_ovf[NCH], m_unf[NCH];
  int m_state;  // 0 running, 1 draining, 2 halted
  int m_peak[NCH], m_stall[NCH];

  outstanding_credit_tracker #(.NUM_CH(NCH), .DEPTH(DEP), .AF_MARGIN(AFM)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ch     (issue_ch),
    .done         (done),
    .drain_req    (drain_req),
    .err_clr      (err_clr),
    .stop         (stop),
    .almost_full  (almost_full),
    .count        (count),
    .drain_done   (drain_done),
`ifdef CREDIT_TRACKER_STATS_EN
    .peak_count   (peak_count),
    .stall_cycles (stall_cycles),
`endif
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_ovf[c] = 0; m_unf[c] = 0; m_peak[c] = 0; m_stall[c] = 0;
    end
    m_state = 0;
  endfunction

  function automatic bit m_stop(int c);
    return (m_cnt[c] == DEP) || (m_state != 0);
  endfunction

  function automatic void model_step(bit iv, int ich, logic [NCH-1:0] dn, bit req, bit clr);
    int  old_cnt[NCH];
    bit  empty;
    empty = 1;
    for (int c = 0; c < NCH; c++) begin
      old_cnt[c] = m_cnt[c];
      if (m_cnt[c] != 0) empty = 0;
    end
    for (int c = 0; c < NCH; c++) begin
      bit inc, dec, so, su, stp;
      inc = iv && (ich == c);
      dec = dn[c];
      stp = m_stop(c);
      so = 0; su = 0;
      if (inc && !dec) begin
        if (stp) so = 1;
        if (old_cnt[c] < DEP) m_cnt[c] = old_cnt[c] + 1;
      end
      if (dec && !inc) begin
        if (old_cnt[c] == 0) su = 1;
        else m_cnt[c] = old_cnt[c] - 1;
      end
      m_ovf[c] = so || (m_ovf[c] && !clr);
      m_unf[c] = su || (m_unf[c] && !clr);
      if (old_cnt[c] > m_peak[c]) m_peak[c] = old_cnt[c];
      if (clr) m_stall[c] = 0;
      else if (stp && m_stall[c] < 65535) m_stall[c]++;
    end
    case (m_state)
      0: if (req) m_state = 1;
      1: if (empty) m_state = 2; else if (!req) m_state = 0;
      default: if (!req) m_state = 0;
    endcase
  endfunction

  // Drives one cycle of stimulus; call after a falling edge, returns after the next one.
  task automatic cycle(input bit iv, input int ich, input logic [NCH-1:0] dn,
                       input bit req, input bit clr);
    issue_valid = iv; issue_ch = ich[0]; done = dn; drain_req = req; err_clr = clr;
    @(posedge clk);
    model_step(iv, ich, dn, req, clr);
    @(negedge clk);
    issue_valid = 1'b0; done = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; drain_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #12;
    checks++;
    if (count !== '0 || stop !== '0 || almost_full !== '0 || drain_done !== 1'b0 ||
        overflow_err !== '0 || underflow_err !== '0) begin
      failures++;
      $display("FAIL reset: count=%h stop=%b af=%b dd=%b ovf=%b unf=%b required all zero",
               count, stop, almost_full, drain_done, overflow_err, underflow_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 0, 2'b00, 0, 0);
      checks++;
      if (count[CW-1:0] !== CW'(i)) begin
        failures++; $display("FAIL fill_count issue %0d: got %0d want %0d", i, count[CW-1:0], i);
      end
      checks++;
      if (almost_full[0] !== (i >= 3)) begin
        failures++; $display("FAIL fill_af issue %0d: got %b want %b", i, almost_full[0], i >= 3);
      end
      checks++;
      if (stop !== {1'b0, i == 4}) begin
        failures++; $display("FAIL fill_stop issue %0d: got %b want %b", i, stop, {1'b0, i == 4});
      end
    end
  endtask

  task automatic test_full_simul();
    cycle(1, 0, 2'b01, 0, 0);
    checks++;
    if (count[CW-1:0] !== 3'd4 || overflow_err[0] !== 1'b0) begin
      failures++; $display("FAIL full_pair: count=%0d ovf=%b want 4/0", count[CW-1:0], overflow_err[0]);
    end
    cycle(1, 0, 2'b00, 0, 0);
    checks++;
    if (count[CW-1:0] !== 3'd4 || overflow_err[0] !== 1'b1) begin
      failures++; $display("FAIL full_overflow: count=%0d ovf=%b want 4/1", count[CW-1:0], overflow_err[0]);
    end
  endtask

  task automatic test_underflow();
    cycle(0, 0, 2'b10, 0, 0);
    checks++;
    if (underflow_err[1] !== 1'b1 || count[2*CW-1:CW] !== 3'd0) begin
      failures++; $display("FAIL underflow_set: unf=%b count1=%0d want 1/0", underflow_err[1], count[2*CW-1:CW]);
    end
    cycle(0, 0, 2'b10, 0, 1);
    checks++;
    if (underflow_err[1] !== 1'b1) begin
      failures++; $display("FAIL underflow_set_beats_clr: got %b want 1", underflow_err[1]);
    end
    cycle(0, 0, 2'b00, 0, 1);
    checks++;
    if (underflow_err !== 2'b00 || overflow_err !== 2'b00) begin
      failures++; $display("FAIL err_clr: unf=%b ovf=%b want 00/00", underflow_err, overflow_err);
    end
  endtask

  task automatic test_drain();
    logic [NCH-1:0] dn_seq [3];
    do_reset();
    cycle(1, 0, 2'b00, 0, 0);
    cycle(1, 0, 2'b00, 0, 0);
    cycle(1, 1, 2'b00, 0, 0);
    cycle(0, 0, 2'b00, 1, 0);
    checks++;
    if (stop !== 2'b11 || drain_done !== 1'b0) begin
      failures++; $display("FAIL drain_stop: stop=%b dd=%b want 11/0", stop, drain_done);
    end
    dn_seq[0] = 2'b01; dn_seq[1] = 2'b01; dn_seq[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, dn_seq[i], 1, 0);
      checks++;
      if (drain_done !== 1'b0) begin
        failures++; $display("FAIL drain_early pulse %0d: got %b want 0", i, drain_done);
      end
    end
    cycle(0, 0, 2'b00, 1, 0);
    checks++;
    if (drain_done !== 1'b1 || drain_done !== (m_state == 2)) begin
      failures++; $display("FAIL drain_done: got %b want 1", drain_done);
    end
    cycle(0, 0, 2'b00, 0, 0);
    checks++;
    if (stop !== 2'b00 || drain_done !== 1'b0) begin
      failures++; $display("FAIL drain_release: stop=%b dd=%b want 00/0", stop, drain_done);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'b00, 0, 0);
    cycle(0, 0, 2'b10, 0, 0);
    cycle(0, 0, 2'b00, 1, 0);
    cycle(0, 0, 2'b00, 1, 0);
    checks++;
    if (count[CW-1:0] !== 3'd3 || stop !== 2'b11 || underflow_err[1] !== 1'b1) begin
      failures++; $display("FAIL async_setup: count0=%0d stop=%b unf=%b want 3/11/1",
                           count[CW-1:0], stop, underflow_err[1]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (count !== '0 || stop !== '0 || drain_done !== 1'b0 || overflow_err !== '0 ||
        underflow_err !== '0 || almost_full !== '0) begin
      failures++; $display("FAIL async_reset: count=%h stop=%b dd=%b ovf=%b unf=%b want all zero",
                           count, stop, drain_done, overflow_err, underflow_err);
    end
    model_reset();
    drain_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef CREDIT_TRACKER_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'b00, 0, 0);
    checks++;
    if (peak_count[CW-1:0] !== 3'd4 || stall_cycles[15:0] !== 16'd5) begin
      failures++; $display("FAIL stats: peak=%0d stall=%0d want 4/5", peak_count[CW-1:0], stall_cycles[15:0]);
    end
    checks++;
    if (stall_cycles[31:16] !== 16'd0) begin
      failures++; $display("FAIL stats_ch1: stall=%0d want 0", stall_cycles[31:16]);
    end
  endtask
`endif

  task automatic test_random();
    bit req;
    do_reset();
    req = 0;
    for (int n = 0; n < 400; n++) begin
      bit iv, clr;
      int ich;
      logic [NCH-1:0] dn;
      iv  = ($urandom_range(0, 1) == 1);
      ich = $urandom_range(0, NCH - 1);
      dn[0] = ($urandom_range(0, 2) == 0);
      dn[1] = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 11) == 0) req = !req;
      cycle(iv, ich, dn, req, clr);
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (count[c*CW +: CW] !== CW'(m_cnt[c]) || stop[c] !== m_stop(c) ||
            almost_full[c] !== (m_cnt[c] >= DEP - AFM) ||
            overflow_err[c] !== m_ovf[c] || underflow_err[c] !== m_unf[c]) begin
          failures++;
          $display("FAIL random cyc %0d ch %0d: cnt=%0d stop=%b af=%b ovf=%b unf=%b want cnt=%0d stop=%b af=%b ovf=%b unf=%b",
                   n, c, count[c*CW +: CW], stop[c], almost_full[c], overflow_err[c], underflow_err[c],
                   m_cnt[c], m_stop(c), m_cnt[c] >= DEP - AFM, m_ovf[c], m_unf[c]);
        end
`ifdef CREDIT_TRACKER_STATS_EN
        checks++;
        if (peak_count[c*CW +: CW] !== CW'(m_peak[c]) || stall_cycles[c*16 +: 16] !== 16'(m_stall[c])) begin
          failures++;
          $display("FAIL random_stats cyc %0d ch %0d: peak=%0d stall=%0d want %0d/%0d",
                   n, c, peak_count[c*CW +: CW], stall_cycles[c*16 +: 16], m_peak[c], m_stall[c]);
        end
`endif
      end
      checks++;
      if (drain_done !== (m_state == 2)) begin
        failures++; $display("FAIL random_drain cyc %0d: got %b want %b", n, drain_done, m_state == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_simul();
    test_underflow();
    test_drain();
    test_async_reset();
`ifdef CREDIT_TRACKER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
